// File: rtl/monishvr_fifo_pkg.sv
// Shared constants and types for the monishvr_fifo block.
//   FIFO_DEPTH / FIFO_WIDTH : default geometry of the buffer
//   *_BIT / *_LSB           : positions of the fields on the TinyTapeout pins
//   fifo_status_t           : flag bundle produced by fifo_core
//   fifo_cnt_w()            : width of an occupancy counter that can hold 0..depth
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_WIDTH = 4;

  // ui_in fields
  localparam int WR_EN_BIT = 2;
  localparam int RD_EN_BIT = 3;
  localparam int DATA_LSB  = 4;

  // uo_out fields
  localparam int FULL_BIT  = 0;
  localparam int EMPTY_BIT = 1;
  localparam int DOUT_LSB  = 2;
  localparam int OVF_BIT   = 6;
  localparam int UDF_BIT   = 7;

  // The uio pins drive the count on [3:0] and are inputs on [7:4].
  localparam logic [7:0] UIO_OE_VAL = 8'h0F;

  typedef struct packed {
    logic underflow;
    logic overflow;
    logic full;
    logic empty;
  } fifo_status_t;

  // One extra bit over the pointer width so that a completely full buffer
  // (count == depth) is distinguishable from an empty one.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/monishvr_fifo_if.sv
// TinyTapeout user-project pin bundle for monishvr_fifo.
//   ena     : project enable from the harness
//   ui_in   : dedicated inputs  (enables and write data)
//   uo_out  : dedicated outputs (flags and read data)
//   uio_in  : bidirectional pins, input side
//   uio_out : bidirectional pins, output side (occupancy count)
//   uio_oe  : bidirectional pin output enables
// master = harness side, slave = user project side.
interface monishvr_fifo_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/monishvr_fifo_core.sv
// Generic DEPTH x WIDTH synchronous FIFO with registered read data.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset of pointers, count, read data, errors
//   wr_req  : write request (level, one word per edge)
//   rd_req  : read request  (level, one word per edge)
//   din     : write data
//   dout    : read-data register, updated one edge after an accepted read
//   count   : occupancy 0..DEPTH
//   status  : full/empty (from count) and sticky overflow/underflow
// Storage is not reset; only control state and the read-data register are.
module fifo_core
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req,
  input  logic                         rd_req,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [fifo_cnt_w(DEPTH)-1:0] count,
  output fifo_status_t                 status
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rd_data_p1;
  logic             ovf;
  logic             udf;

  logic full;
  logic empty;
  logic rd_ok;
  logic wr_ok;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // A read is only refused when empty, so when full a simultaneous read
  // always frees the slot the write needs.
  assign rd_ok = rd_req && !empty;
  assign wr_ok = wr_req && (!full || rd_ok);

  // Storage: no reset; pointers decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Control and read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rd_data_p1 <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        // When full with both enables, rd_ptr == wr_ptr: the old head is
        // captured here before the write lands in the same entry.
        rd_data_p1 <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_req && !wr_ok) begin
        ovf <= 1'b1;
      end
      if (rd_req && empty) begin
        udf <= 1'b1;
      end
    end
  end

  assign dout             = rd_data_p1;
  assign count            = cnt;
  assign status.full      = full;
  assign status.empty     = empty;
  assign status.overflow  = ovf;
  assign status.underflow = udf;

endmodule

// File: rtl/monishvr_fifo.sv
// TinyTapeout wrapper around fifo_core.
//   clk   : system clock
//   rst_n : asynchronous reset, active HIGH (1 = reset) despite its name
//   pins  : TinyTapeout pin bundle (slave side)
//     ui_in[2]=wr_en, ui_in[3]=rd_en, ui_in[7:4]=write data
//     uo_out[0]=full, [1]=empty, [5:2]=read data, [6]=overflow, [7]=underflow
//     uio_out[3:0]=count, uio_oe=8'h0F
// ena, uio_in and ui_in[1:0] are not used; the FIFO runs whenever clocked.
module monishvr_fifo
  import fifo_pkg::*;
#(
  // Count is reported on four pins, so DEPTH may not exceed 8.
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  monishvr_fifo_if.slave  pins
);

  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic [FIFO_WIDTH-1:0] dout;
  logic [CNT_W-1:0]      count;
  fifo_status_t          status;
  logic [7:0]            cnt_ext;
  logic                  unused_pins;

  fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst_n),
    .wr_req (pins.ui_in[WR_EN_BIT]),
    .rd_req (pins.ui_in[RD_EN_BIT]),
    .din    (pins.ui_in[DATA_LSB +: FIFO_WIDTH]),
    .dout   (dout),
    .count  (count),
    .status (status)
  );

  assign cnt_ext = 8'(count);

  always_comb begin
    pins.uo_out                          = 8'h00;
    pins.uo_out[FULL_BIT]                = status.full;
    pins.uo_out[EMPTY_BIT]               = status.empty;
    pins.uo_out[DOUT_LSB +: FIFO_WIDTH]  = dout;
    pins.uo_out[OVF_BIT]                 = status.overflow;
    pins.uo_out[UDF_BIT]                 = status.underflow;
  end

  assign pins.uio_out = {4'h0, cnt_ext[3:0]};
  assign pins.uio_oe  = UIO_OE_VAL;

  assign unused_pins = &{1'b0, pins.ena, pins.uio_in, pins.ui_in[1:0]};

endmodule

// File: tb/tb_monishvr_fifo.sv
// Directed bench for monishvr_fifo: reset values, single words, fill/wrap,
// overflow/underflow, simultaneous enables and asynchronous reset.
module tb_monishvr_fifo;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  monishvr_fifo_if pins ();

  monishvr_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given enables; outputs sampled 1 time unit after it.
  task automatic cyc(input bit wr, input bit rd, input logic [3:0] d);
    pins.ui_in = {d, rd, wr, 2'b00};
    @(posedge clk);
    #1;
    pins.ui_in = 8'h00;
  endtask

  function automatic logic [3:0] dout();
    return pins.uo_out[5:2];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b1;
    pins.ena    = 1'b1;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;

    // Reset state
    do_reset();
    #1;
    chk("rst_uo_out", 32'(pins.uo_out), 32'h02);
    chk("rst_uio_out", 32'(pins.uio_out), 32'h00);
    chk("rst_uio_oe", 32'(pins.uio_oe), 32'h0F);

    // Single word A, then C
    cyc(1, 0, 4'hA);
    chk("one_count", 32'(pins.uio_out), 32'h01);
    chk("one_empty", 32'(pins.uo_out[1]), 32'h0);
    cyc(0, 1, 4'h0);
    chk("one_dout", 32'(dout()), 32'hA);
    chk("one_empty_after", 32'(pins.uo_out[1]), 32'h1);
    cyc(0, 0, 4'h0);
    chk("one_hold", 32'(dout()), 32'hA);
    cyc(1, 0, 4'hC);
    cyc(0, 1, 4'h0);
    chk("two_dout", 32'(dout()), 32'hC);

    // Fill 1..8, overflow, drain
    for (int i = 1; i <= 8; i++) cyc(1, 0, 4'(i));
    chk("fill_count", 32'(pins.uio_out), 32'h08);
    chk("fill_full", 32'(pins.uo_out[0]), 32'h1);
    cyc(1, 0, 4'hF);
    chk("ovf_flag", 32'(pins.uo_out[6]), 32'h1);
    chk("ovf_count", 32'(pins.uio_out), 32'h08);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 4'h0);
      chk($sformatf("drain1_%0d", i), 32'(dout()), 32'(i));
    end
    chk("drain1_empty", 32'(pins.uo_out[1]), 32'h1);

    // Second round 9..F,0 crosses the pointer wrap
    for (int i = 9; i <= 16; i++) cyc(1, 0, 4'(i));
    chk("fill2_full", 32'(pins.uo_out[0]), 32'h1);
    for (int i = 9; i <= 16; i++) begin
      cyc(0, 1, 4'h0);
      chk($sformatf("drain2_%0d", i), 32'(dout()), 32'(i & 15));
    end
    chk("ovf_sticky", 32'(pins.uo_out[6]), 32'h1);

    // Underflow: read while empty; data holds last value 0
    cyc(0, 1, 4'h0);
    chk("udf_uo_out", 32'(pins.uo_out), 32'hC2);
    cyc(0, 0, 4'h0);
    chk("udf_sticky", 32'(pins.uo_out[7]), 32'h1);

    do_reset();
    #1;
    chk("rst2_uo_out", 32'(pins.uo_out), 32'h02);

    // Both enables while empty: write only, underflow set
    cyc(1, 1, 4'h5);
    chk("simE_count", 32'(pins.uio_out), 32'h01);
    chk("simE_udf", 32'(pins.uo_out[7]), 32'h1);
    chk("simE_dout", 32'(dout()), 32'h0);
    cyc(0, 1, 4'h0);
    chk("simE_read", 32'(dout()), 32'h5);

    // Both enables while full: head out, new word in
    for (int i = 1; i <= 8; i++) cyc(1, 0, 4'(i));
    cyc(1, 1, 4'h9);
    chk("simF_dout", 32'(dout()), 32'h1);
    chk("simF_count", 32'(pins.uio_out), 32'h08);
    chk("simF_noovf", 32'(pins.uo_out[6]), 32'h0);
    for (int i = 2; i <= 9; i++) begin
      cyc(0, 1, 4'h0);
      chk($sformatf("simF_rd_%0d", i), 32'(dout()), 32'(i));
    end
    chk("simF_empty", 32'(pins.uo_out[1]), 32'h1);

    // Asynchronous reset between edges
    cyc(1, 0, 4'h7);
    cyc(1, 0, 4'h6);
    cyc(0, 1, 4'h0);
    chk("async_pre_dout", 32'(dout()), 32'h7);
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_uo_out", 32'(pins.uo_out), 32'h02);
    chk("async_uio_out", 32'(pins.uio_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b0;
    cyc(0, 0, 4'h0);
    chk("async_after", 32'(pins.uo_out), 32'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/monishvr_fifo.md
Name: monishvr_fifo

Overview:
- Small synchronous FIFO wrapped in the standard TinyTapeout user-project pin interface.
- Buffers 4-bit words written from dedicated input pins and returns them in order on output pins.
- Drives full/empty flags, sticky overflow/underflow error flags and an occupancy count for the chip-level harness.

Parameters:
- DEPTH, 8, number of 4-bit entries; power of two, at least 2.
- WIDTH, 4, data word width; fixed by the pin map and not overridable at top level.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-HIGH reset despite the codebase name; 1 = reset asserted.
- ena  in  1  TinyTapeout enable; ignored, FIFO runs whenever clocked.
- ui_in  in  8  [2]=wr_en, [3]=rd_en, [7:4]=write data, [1:0] unused.
- uo_out  out  8  [0]=full, [1]=empty, [5:2]=read data, [6]=overflow (sticky), [7]=underflow (sticky).
- uio_in  in  8  unused.
- uio_out  out  8  [3:0]=occupancy count (0..DEPTH), [7:4]=0.
- uio_oe  out  8  constant 8'h0F.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - write pointer, read pointer and count = 0
  - read-data register = 4'h0; overflow = 0; underflow = 0
  - therefore empty=1, full=0, uo_out=8'h02, uio_out=8'h00
  - memory contents are not reset
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0. Count: log2(DEPTH)+1 bits.
- Flags are combinational from the count: full = (count==DEPTH), empty = (count==0).
- Write accepted on a rising edge when wr_en=1 and either not full, or full with a read accepted in the same edge.
  - Effect: mem[wr_ptr] <= ui_in[7:4]; wr_ptr increments.
- Read accepted on a rising edge when rd_en=1 and not empty.
  - Effect: read-data register <= mem[rd_ptr]; rd_ptr increments.
  - Data is visible on uo_out[5:2] after that edge, so read latency is 1 cycle.
  - The read-data register holds its value until the next accepted read.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Simultaneous rd_en and wr_en:
  - When empty: only the write is accepted. The read is rejected and underflow is set. No write-through bypass.
  - When full: both are accepted. The old head is read out, the new word is stored, and count stays at DEPTH.
  - Otherwise: both are accepted.
- wr_en=1 while full without an accepted read: write dropped, overflow <= 1. Memory and pointers unchanged.
- rd_en=1 while empty: underflow <= 1. Read-data register and pointers unchanged.
- Overflow and underflow remain set until reset.
- Enables are level-sensitive: holding wr_en high for N edges performs up to N writes.
- Reset asserted mid-operation immediately empties the FIFO and clears the data output. There is no recovery of previous contents.

Decomposition:
- Shared package fifo_pkg:
  - constants FIFO_DEPTH=8, FIFO_WIDTH=4
  - pin-index constants WR_EN_BIT=2, RD_EN_BIT=3, DATA_LSB=4, FULL_BIT=0, EMPTY_BIT=1, DOUT_LSB=2
- One natural sub-module, fifo_core: generic DEPTH x WIDTH storage, pointers, count, flags and error bits.
- Top level monishvr_fifo only maps pins onto fifo_core and ties off unused outputs.

Test Plan:
- Reset: pulse rst_n high for 1 cycle, then low -> uo_out=8'h02, uio_out=8'h00, uio_oe=8'h0F.
- Single word: write 4'hA for one edge -> count=1, empty=0. Read one edge later -> uo_out[5:2]=4'hA, empty=1, data holds after rd_en drops. Then write 4'hC and read -> uo_out[5:2]=4'hC.
- Fill/wrap:
  - Write 1..8 -> full=1, count=8. A 9th write of 4'hF sets overflow; count stays 8.
  - Read 8 times -> outputs 1..8 in order, then empty=1.
  - Repeat with 9..F,0 to exercise pointer wrap.
- Underflow: rd_en while empty -> underflow=1, uo_out[5:2] unchanged. Stays 1 until reset.
- Simultaneous:
  - Both enables while empty -> count=1, underflow=1; a later read returns the written word.
  - Both enables while full (head=1, new=4'h9) -> output 1, count=8; the last word read out is 4'h9.
- Async reset: assert rst_n mid-stream between clock edges -> flags, count and data clear immediately, without waiting for a clock edge.
